// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 serial receive controller.
// Synchronises the raw rx line, times mid-bit sample points with a local
// bit-rate counter, and hands each good byte to the core over a valid/ack
// handshake with framing-error and overrun reporting.
//
// Handshake: rx_valid rises when a good frame completes and stays high until
// the consumer raises rx_ack while rx_valid=1; the flag (and overrun) clear on
// the following edge. rx_ack while rx_valid=0 has no effect. A good frame that
// completes while rx_valid=1 overwrites rx_data and sets overrun, unless
// rx_ack is high on that same edge, in which case the new byte is treated as
// a fresh delivery (rx_valid stays 1, overrun clears).
module uart_rx_ctrl #(
  parameter int DELAY_COUNTS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(DELAY_COUNTS);
  localparam logic [CW-1:0] HALF = CW'((DELAY_COUNTS - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(DELAY_COUNTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t        state;
  state_t        state_nxt;

  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic          end_half;
  logic          end_bit;
  logic          cnt_clr;
  logic          shift_en;
  logic          frame_good;
  logic          frame_bad;

  assign end_half = (cnt == HALF);
  assign end_bit  = (cnt == LAST);
  assign busy     = (state != IDLE);

  // two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (end_half) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (end_bit && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:    if (end_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control outputs for the datapath
  always_comb begin
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE:  cnt_clr = 1'b1;
      START: cnt_clr = end_half && !rx_s;
      DATA:  shift_en = end_bit;
      STOP: begin
        frame_good = end_bit && rx_s;
        frame_bad  = end_bit && !rx_s;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // bit-rate counter: wraps every DELAY_COUNTS cycles, restarted at frame and data start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (end_bit) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  // bit index and LSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (cnt_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
    end
  end

  // delivery register, handshake flags and framing-error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      if (frame_good) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
        overrun  <= rx_valid && !rx_ack;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with DELAY_COUNTS=16.
// All stimulus is applied 1 time unit after a rising edge; a frame whose
// start bit is driven after edge t must report at edge t+155 (t+3+152).
module tb_uart_rx_ctrl;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // monitor state
  int   valid_rise  = -1;
  int   busy_rise   = -1;
  int   ferr_cnt    = 0;
  int   busy_cycles = 0;
  logic valid_q     = 1'b0;
  logic busy_q      = 1'b0;

  logic [7:0] exp_q[$];
  int         t0;

  uart_rx_ctrl #(.DELAY_COUNTS(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  // clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // edge bookkeeping sampled mid-cycle
  always @(negedge clk) begin
    if (rx_valid && !valid_q) valid_rise = cyc;
    if (busy && !busy_q) busy_rise = cyc;
    if (framing_err) ferr_cnt = ferr_cnt + 1;
    if (busy) busy_cycles = busy_cycles + 1;
    valid_q = rx_valid;
    busy_q  = busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drive one 8N1 frame; stop level held for 'hold' edges, then return
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int hold,
                            output int start_cyc);
    start_cyc  = cyc;
    valid_rise = -1;
    busy_rise  = -1;
    rx = 1'b0;
    tick(D);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(D);
    end
    rx = stop_bit;
    tick(hold);
  endtask

  initial begin
    rst    = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;
    tick(3);

    // reset state
    check_eq("rst_data", 32'(rx_data), 32'h0);
    check_eq("rst_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_ferr", 32'(framing_err), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(4);

    // good frame 0x55, latency and ack
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 11, t0);
    check_eq("f55_busy_rise", 32'(busy_rise), 32'(t0 + 3));
    check_eq("f55_valid", 32'(rx_valid), 32'h1);
    check_eq("f55_busy_off", 32'(busy), 32'h0);
    check_eq("f55_data", 32'(rx_data), 32'(exp_q.pop_front()));
    check_eq("f55_overrun", 32'(overrun), 32'h0);
    tick(1);
    check_eq("f55_valid_rise", 32'(valid_rise), 32'(t0 + 155));
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check_eq("f55_ack_clr", 32'(rx_valid), 32'h0);
    tick(4);
    check_eq("f55_ack_idle", 32'(rx_valid), 32'h0);

    // framing error on 0xA3
    send_frame(8'hA3, 1'b0, 11, t0);
    check_eq("fa3_ferr", 32'(framing_err), 32'h1);
    check_eq("fa3_valid", 32'(rx_valid), 32'h0);
    check_eq("fa3_data_kept", 32'(rx_data), 32'h55);
    rx = 1'b1;
    tick(1);
    check_eq("fa3_ferr_pulse", 32'(framing_err), 32'h0);
    tick(30);
    check_eq("fa3_ferr_cnt", 32'(ferr_cnt), 32'h1);
    check_eq("fa3_idle", 32'(busy), 32'h0);
    check_eq("fa3_no_valid", 32'(rx_valid), 32'h0);

    // start-bit glitch of 4 cycles
    busy_cycles = 0;
    busy_rise   = -1;
    t0 = cyc;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    check_eq("glitch_busy_rise", 32'(busy_rise), 32'(t0 + 3));
    check_eq("glitch_busy_len", 32'(busy_cycles), 32'd8);
    check_eq("glitch_no_valid", 32'(rx_valid), 32'h0);
    check_eq("glitch_no_ferr", 32'(ferr_cnt), 32'h1);

    // overrun: 0x12 then 0x34 without ack
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 11, t0);
    check_eq("ov_first_data", 32'(rx_data), 32'(exp_q.pop_front()));
    check_eq("ov_first_overrun", 32'(overrun), 32'h0);
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1, 11, t0);
    check_eq("ov_second_data", 32'(rx_data), 32'(exp_q.pop_front()));
    check_eq("ov_second_valid", 32'(rx_valid), 32'h1);
    check_eq("ov_second_overrun", 32'(overrun), 32'h1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check_eq("ov_ack_valid", 32'(rx_valid), 32'h0);
    check_eq("ov_ack_overrun", 32'(overrun), 32'h0);
    tick(4);

    // ack on the completion edge of a new frame
    exp_q.push_back(8'h56);
    send_frame(8'h56, 1'b1, 11, t0);
    check_eq("sim_a_data", 32'(rx_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h78);
    send_frame(8'h78, 1'b1, 11, t0);
    check_eq("sim_b_data", 32'(rx_data), 32'(exp_q.pop_front()));
    check_eq("sim_b_overrun", 32'(overrun), 32'h1);
    exp_q.push_back(8'h9A);
    send_frame(8'h9A, 1'b1, 10, t0);
    check_eq("sim_pre_data", 32'(rx_data), 32'h78);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check_eq("sim_valid", 32'(rx_valid), 32'h1);
    check_eq("sim_data", 32'(rx_data), 32'(exp_q.pop_front()));
    check_eq("sim_overrun", 32'(overrun), 32'h0);
    tick(1);
    check_eq("sim_valid_hold", 32'(rx_valid), 32'h1);
    tick(4);

    // reset during data bit 3
    rx = 1'b0;
    tick(D);
    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      tick(D);
    end
    rx = 1'b0;
    tick(8);
    check_eq("mid_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_data", 32'(rx_data), 32'h0);
    check_eq("mid_rst_valid", 32'(rx_valid), 32'h0);
    check_eq("mid_rst_overrun", 32'(overrun), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_ferr", 32'(framing_err), 32'h0);
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    exp_q.push_back(8'hC7);
    send_frame(8'hC7, 1'b1, 11, t0);
    check_eq("c7_valid", 32'(rx_valid), 32'h1);
    check_eq("c7_data", 32'(rx_data), 32'(exp_q.pop_front()));
    check_eq("c7_overrun", 32'(overrun), 32'h0);
    tick(1);
    check_eq("c7_valid_rise", 32'(valid_rise), 32'(t0 + 155));
    check_eq("c7_ferr_cnt", 32'(ferr_cnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Serial RS-232 (8N1) receive controller. It synchronises the asynchronous `rx` line and runs its own bit-rate counter to find mid-bit sample points. A four-state FSM sequences start validation, data capture and stop check, and delivers each byte to the core through a valid/ack handshake with framing-error and overrun reporting. It sits between the board UART pin and the memory-mapped UART register block.

## Interface
- `DELAY_COUNTS`, 16: clock cycles per serial bit (D). Legal range D ≥ 4.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw serial line, asynchronous, idle high.
- `rx_ack`  in  1  consumer acknowledges the byte; sampled only while `rx_valid`=1.
- `rx_data`  out  8  last good received byte, registered.
- `rx_valid`  out  1  byte available; held until acked.
- `framing_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `overrun`  out  1  sticky; a new byte arrived while `rx_valid` was still 1.
- `busy`  out  1  FSM state is not IDLE.

## Operation
- Reset values: all outputs 0, both synchroniser flops 1, state IDLE, counter 0, bit index 0, shift register 0.
- Synchroniser: two flops, `rx` → `rx_s`. All FSM decisions use `rx_s`.
- Bit counter `cnt`:
  - Width $clog2(D).
  - Counts 0..D-1 and wraps to 0 while the state is not IDLE.
  - Forced to 0 in IDLE.
  - `end_half` = (cnt == (D-1)/2), integer division. `end_bit` = (cnt == D-1).
- IDLE: when `rx_s`=0, go to START with cnt←0.
- START: at `end_half`:
  - `rx_s`=0: cnt←0, bit index←0, go to DATA.
  - `rx_s`=1: glitch; return to IDLE with nothing reported.
- DATA: at each `end_bit`:
  - Shift LSB-first: shift←{`rx_s`, shift[7:1]}, bit index+1.
  - After the 8th sample, go to STOP.
- STOP: at `end_bit`, sample `rx_s`, then go to IDLE.
  - `rx_s`=1: `rx_data`←shift, `rx_valid`←1.
  - `rx_s`=0: `framing_err` pulses for 1 cycle. `rx_data`, `rx_valid` and `overrun` are unchanged.
- Handshake:
  - `rx_ack`=1 with `rx_valid`=1 clears `rx_valid` and `overrun` on the next edge.
  - `rx_ack` while `rx_valid`=0 is ignored.
- Overrun: a good frame completes while `rx_valid`=1 and `rx_ack`=0. Then `rx_data` is overwritten with the new byte, `rx_valid` stays 1, `overrun`←1.
- Simultaneous ack and completion: the new byte wins. `rx_valid` stays 1, `rx_data` takes the new byte, `overrun`←0.
- `rst` mid-frame: immediate return to reset values. The partial frame is discarded.

## Timing
- Line to FSM latency: `rx` falling before edge a is seen by the FSM after edge a+1. START is entered at edge e0 = a+2.
- Start validated (DATA entered) at edge e0+H+1, where H=(D-1)/2.
- Data bit k (k = 0..7) is sampled at edge e0+H+1+(k+1)·D.
- STOP is entered at edge e0+H+1+8D.
- `rx_valid` or `framing_err` is asserted at edge e0+H+1+9D. `busy` falls at that same edge.
- A new start can be accepted on the cycle after the return to IDLE.
- `busy` rises at e0.
- `framing_err` is exactly one cycle wide.
- With D=16: H=7, and `rx_valid` rises 152 edges after e0.

## Test plan
- D=16; send 0x55 with stop=1 → `rx_valid` rises at e0+152 with `rx_data`=0x55; `rx_ack` one cycle later → `rx_valid`=0 the following cycle.
- Send 0xA3 with the stop bit driven 0 → one-cycle `framing_err` at e0+152; `rx_valid`=0; `rx_data` keeps its previous value.
- Drive `rx` low for 4 cycles, then high → `busy` for H+1 cycles, then IDLE; no `rx_valid`, no `framing_err`.
- Send 0x12 and then 0x34 with no ack → after the second frame `rx_data`=0x34, `rx_valid`=1, `overrun`=1; `rx_ack` clears both flags.
- Assert `rx_ack` on the exact cycle the second frame completes → `rx_valid`=1, `rx_data`=second byte, `overrun`=0.
- Assert `rst` during data bit 3 → all outputs 0 immediately; a following clean 0xC7 frame is received correctly.
